// File: rtl/imem_boot_loader.sv
// Boot-time loader: receives a length-prefixed, XOR-checksummed byte stream, writes
// little-endian words into instruction memory and holds the core in reset until verified.
module imem_boot_loader #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W   = 17;
  localparam logic [IDX_W-1:0] DEPTH_W = IDX_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LOAD, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [7:0]         xor_q, xor_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               in_ready_q, in_ready_d;
  logic               imem_we_q, imem_we_d;
  logic [31:0]        imem_addr_q, imem_addr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;
  logic               core_rst_q, core_rst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               xfer_c;
  logic [31:0]        word_c;
  logic [IDX_W-1:0]   n_c;
  logic [IDX_W-1:0]   idx_inc_c;

  assign xfer_c    = in_valid & in_ready_q;
  assign n_c       = {1'b0, in_data, len_lo_q};
  assign idx_inc_c = word_idx_q + IDX_W'(1);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_cnt_d   = byte_cnt_q;
    xor_d        = xor_q;
    wdata_d      = wdata_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    word_c = wdata_q;
    word_c[{byte_cnt_q, 3'b000} +: 8] = in_data;

    case (state_q)
      S_IDLE: begin
        if (xfer_c) begin
          len_lo_d = in_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer_c) begin
          len_d      = n_c;
          word_idx_d = '0;
          byte_cnt_d = '0;
          xor_d      = '0;
          wdata_d    = '0;
          if (n_c > DEPTH_W)      state_d = S_ERR;
          else if (n_c == '0)     state_d = S_CHECK;
          else                    state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer_c) begin
          wdata_d    = word_c;
          xor_d      = xor_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d      = S_WRITE;
            imem_we_d    = 1'b1;
            imem_addr_d  = 32'({word_idx_q, 2'b00});
            imem_wdata_d = word_c;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = idx_inc_c;
        state_d    = (idx_inc_c == len_q) ? S_CHECK : S_LOAD;
      end
      S_CHECK: begin
        if (xfer_c) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: state_d = state_q;
      default:       state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_LEN_HI) ||
                 (state_d == S_LOAD) || (state_d == S_CHECK);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    core_rst_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      xor_q        <= '0;
      wdata_q      <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      xor_q        <= xor_d;
      wdata_q      <= wdata_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
